// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and result-word layout for the ALU host driver
package alu_pkg;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
  localparam int POS_ERR   = 7;
  localparam int POS_SIGN  = 6;
  localparam int POS_ZERO  = 5;
  localparam int POS_CARRY = 4;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
endpackage

// File: rtl/alu_host_driver_if.sv
// alu_host_driver_if: command, ALU pin and response signals of the ALU host driver
interface alu_host_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;
  logic [7:0] alu_ui;
  logic [1:0] alu_sel;
  logic [7:0] alu_uo;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_sign;
  logic       rsp_err;
  logic       rsp_mismatch;
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_uo, rsp_ready,
    output cmd_ready, alu_ui, alu_sel, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign,
           rsp_err, rsp_mismatch
  );
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_uo, rsp_ready,
    input  cmd_ready, alu_ui, alu_sel, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign,
           rsp_err, rsp_mismatch
  );
endinterface

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational expected result word {0, sign, zero, carry, out} for (a, b, op)
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic [7:0] word
);
  logic [4:0] r;
  // bit 4 is carry for ADD and borrow (a < b) for SUB
  always_comb begin
    r = op == ALU_ADD ? {1'b0, a} + {1'b0, b} :
        op == ALU_SUB ? {1'b0, a} - {1'b0, b} :
        op == ALU_AND ? {1'b0, a & b} : {1'b0, a | b};
    word = {1'b0, r[3], ~|r[3:0], r[4], r[3:0]};
  end
endmodule

// File: rtl/alu_host_driver.sv
// alu_host_driver: drives ALU pins per command, samples result after settle time; ALU_CHECK_EN adds model check
module alu_host_driver
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_host_driver_if.slave  bus,
  output logic              busy,
  output logic [7:0]        mismatch_cnt
);
  localparam int S = SETTLE_CYCLES < SETTLE_MIN ? SETTLE_MIN :
                     SETTLE_CYCLES > SETTLE_MAX ? SETTLE_MAX : SETTLE_CYCLES;
  localparam logic [3:0] LOAD = 4'(S - 1);
  state_t     state, nxt;
  logic [3:0] cnt;
  logic [7:0] ui;
  logic [1:0] sel;
  logic [7:0] word;
  logic       acc, cap;
  always_comb begin
    acc = state == IDLE && bus.cmd_valid;
    cap = state == DRIVE && cnt == 4'd0;
    nxt = state == IDLE  ? (bus.cmd_valid ? DRIVE : IDLE) :
          state == DRIVE ? (cnt == 4'd0 ? RESP : DRIVE) :
                           (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ui    <= '0;
      sel   <= '0;
      word  <= '0;
    end else begin
      state <= nxt;
      if (acc) begin
        ui  <= {bus.cmd_b, bus.cmd_a};
        sel <= bus.cmd_op;
        cnt <= LOAD;
      end else if (state == DRIVE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (cap) word <= bus.alu_uo;
    end
  end
  assign bus.cmd_ready  = state == IDLE;
  assign bus.rsp_valid  = state == RESP;
  assign busy           = state != IDLE;
  assign bus.alu_ui     = ui;
  assign bus.alu_sel    = sel;
  assign bus.rsp_result = word[3:0];
  assign bus.rsp_carry  = word[POS_CARRY];
  assign bus.rsp_zero   = word[POS_ZERO];
  assign bus.rsp_sign   = word[POS_SIGN];
  assign bus.rsp_err    = word[POS_ERR];
`ifdef ALU_CHECK_EN
  logic [7:0] exp_word;
  logic       mm;
  logic [7:0] mcnt;
  alu_ref_model u_ref (.a(ui[3:0]), .b(ui[7:4]), .op(sel), .word(exp_word));
  always_ff @(posedge clk) begin
    if (rst) begin
      mm   <= 1'b0;
      mcnt <= '0;
    end else if (cap) begin
      mm <= bus.alu_uo != exp_word;
      if (bus.alu_uo != exp_word && mcnt != 8'hFF) mcnt <= mcnt + 8'd1;
    end
  end
  assign bus.rsp_mismatch = mm;
  assign mismatch_cnt     = mcnt;
`else
  assign bus.rsp_mismatch = 1'b0;
  assign mismatch_cnt     = '0;
`endif
endmodule

// File: tb/tb_alu_host_driver.sv
// tb_alu_host_driver: table-driven, hand sequences and randomized checks against an integer ALU model
module tb_alu_host_driver;
  import alu_pkg::*;
`ifdef ALU_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int S4 = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] uo4 = 8'h00;
  logic       busy4, busy1;
  logic [7:0] mc4, mc1;
  int         total = 0;
  int         bad = 0;
  int         model_cnt = 0;
  alu_host_driver_if b4();
  alu_host_driver_if b1();
  assign b4.alu_uo = uo4;
  assign b1.alu_uo = 8'h11;
  alu_host_driver #(.SETTLE_CYCLES(S4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave), .busy(busy4), .mismatch_cnt(mc4));
  alu_host_driver #(.SETTLE_CYCLES(1))  u1 (.clk(clk), .rst(rst), .bus(b1.slave), .busy(busy1), .mismatch_cnt(mc1));
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [7:0] uo;
    bit         mm;
  } vec_t;

  function automatic logic [7:0] alu_word(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int r;
    logic [3:0] o;
    logic c;
    r = op == 2'd0 ? int'(a) + int'(b) : op == 2'd1 ? int'(a) - int'(b) : op == 2'd2 ? int'(a & b) : int'(a | b);
    o = r[3:0];
    c = (op == 2'd0 && r > 15) || (op == 2'd1 && r < 0);
    return {1'b0, o[3], o == 4'd0, c, o};
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  // one full transaction on the SETTLE=4 driver; hold>0 stalls rsp_ready while a new command waits
  task automatic txn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                     input logic [7:0] uo, input bit mm, input int hold);
    int cyc;
    uo4 = uo;
    b4.cmd_a = a;
    b4.cmd_b = b;
    b4.cmd_op = op;
    b4.cmd_valid = 1'b1;
    b4.rsp_ready = 1'b0;
    cyc = 0;
    while (!b4.cmd_ready && cyc < 40) begin @(negedge clk); cyc++; end
    chk("accept_wait", 32'(cyc < 40), 1);
    @(negedge clk);
    b4.cmd_valid = 1'b0;
    chk("pins_ui", b4.alu_ui, {b, a});
    chk("pins_sel", b4.alu_sel, op);
    chk("busy", busy4, 1);
    cyc = 0;
    while (!b4.rsp_valid && cyc < 40) begin @(negedge clk); cyc++; end
    chk("latency", cyc, S4);
    if (CHK && mm) model_cnt = model_cnt < 255 ? model_cnt + 1 : 255;
    chk("result", b4.rsp_result, uo[3:0]);
    chk("carry", b4.rsp_carry, uo[4]);
    chk("zero", b4.rsp_zero, uo[5]);
    chk("sign", b4.rsp_sign, uo[6]);
    chk("err", b4.rsp_err, uo[7]);
    chk("mismatch", b4.rsp_mismatch, CHK & mm);
    chk("mismatch_cnt", mc4, model_cnt);
    for (int i = 0; i < hold; i++) begin
      b4.cmd_a = ~a;
      b4.cmd_b = ~b;
      b4.cmd_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", b4.rsp_valid, 1);
      chk("hold_ready", b4.cmd_ready, 0);
      chk("hold_result", b4.rsp_result, uo[3:0]);
      chk("hold_zero", b4.rsp_zero, uo[5]);
      chk("hold_pins", b4.alu_ui, {b, a});
    end
    b4.rsp_ready = 1'b1;
    @(negedge clk);
    b4.rsp_ready = 1'b0;
    chk("rsp_drop", b4.rsp_valid, 0);
    chk("idle", b4.cmd_ready, 1);
    chk("pins_kept", b4.alu_ui, {b, a});
  endtask

  initial begin
    vec_t tbl[8];
    logic [3:0] a, b;
    logic [1:0] op;
    logic [7:0] x;
    tbl[0] = '{4'h9, 4'h8, ALU_ADD, 8'h11, 1'b0};
    tbl[1] = '{4'h3, 4'h5, ALU_SUB, 8'h5E, 1'b0};
    tbl[2] = '{4'h0, 4'h0, ALU_OR,  8'h20, 1'b0};
    tbl[3] = '{4'hF, 4'hF, ALU_AND, 8'h80, 1'b1};
    tbl[4] = '{4'hF, 4'h1, ALU_ADD, 8'h30, 1'b0};
    tbl[5] = '{4'h5, 4'h3, ALU_SUB, 8'h02, 1'b0};
    tbl[6] = '{4'hA, 4'h6, ALU_AND, 8'h02, 1'b0};
    tbl[7] = '{4'h7, 4'h1, ALU_ADD, 8'h48, 1'b0};
    {b4.cmd_valid, b4.rsp_ready, b4.cmd_a, b4.cmd_b, b4.cmd_op} = '0;
    {b1.cmd_valid, b1.rsp_ready, b1.cmd_a, b1.cmd_b, b1.cmd_op} = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", b4.cmd_ready, 1);
    chk("rst_ui", b4.alu_ui, 0);
    chk("rst_sel", b4.alu_sel, 0);
    chk("rst_rsp_valid", b4.rsp_valid, 0);
    chk("rst_fields", {b4.rsp_result, b4.rsp_carry, b4.rsp_zero, b4.rsp_sign, b4.rsp_err, b4.rsp_mismatch}, 0);
    chk("rst_cnt", mc4, 0);
    chk("rst_busy", busy4, 0);
    rst = 1'b0;
    @(negedge clk);
    // SETTLE=1: ALU pins fixed at 0x11, response one cycle after acceptance
    b1.cmd_a = 4'h9;
    b1.cmd_b = 4'h8;
    b1.cmd_op = ALU_ADD;
    b1.cmd_valid = 1'b1;
    @(negedge clk);
    b1.cmd_valid = 1'b0;
    chk("s1_ui", b1.alu_ui, 8'h89);
    chk("s1_sel", b1.alu_sel, 0);
    chk("s1_early", b1.rsp_valid, 0);
    @(negedge clk);
    chk("s1_valid", b1.rsp_valid, 1);
    chk("s1_result", b1.rsp_result, 1);
    chk("s1_flags", {b1.rsp_carry, b1.rsp_zero, b1.rsp_sign}, 3'b100);
    b1.rsp_ready = 1'b1;
    @(negedge clk);
    b1.rsp_ready = 1'b0;
    chk("s1_drop", b1.rsp_valid, 0);
    for (int i = 0; i < 8; i++) begin
      chk("tbl_model", 32'(alu_word(tbl[i].a, tbl[i].b, tbl[i].op) != tbl[i].uo), 32'(tbl[i].mm));
      txn(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].uo, tbl[i].mm, 0);
    end
    txn(4'h0, 4'h0, ALU_OR, 8'h20, 1'b0, 5);
    txn(4'hF, 4'hF, ALU_OR, 8'h4F, 1'b0, 0);
    for (int i = 0; i < 60; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      op = 2'($urandom);
      x = ($urandom % 4 == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      txn(a, b, op, alu_word(a, b, op) ^ x, x != 8'h00, 0);
    end
    for (int i = 0; i < 256; i++) txn(4'hF, 4'hF, ALU_AND, 8'h80, 1'b1, 0);
    chk("sat_cnt", mc4, CHK ? 255 : 0);
    // reset two cycles into DRIVE discards the command
    uo4 = alu_word(4'h5, 4'hA, ALU_SUB);
    b4.cmd_a = 4'h5;
    b4.cmd_b = 4'hA;
    b4.cmd_op = ALU_SUB;
    b4.cmd_valid = 1'b1;
    @(negedge clk);
    b4.cmd_valid = 1'b0;
    chk("mr_pins", b4.alu_ui, 8'hA5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
    chk("mr_ui", b4.alu_ui, 0);
    chk("mr_sel", b4.alu_sel, 0);
    chk("mr_ready", b4.cmd_ready, 1);
    chk("mr_busy", busy4, 0);
    chk("mr_cnt", mc4, 0);
    for (int i = 0; i < 6; i++) begin
      chk("mr_no_rsp", b4.rsp_valid, 0);
      @(negedge clk);
    end
    txn(4'h5, 4'hA, ALU_SUB, alu_word(4'h5, 4'hA, ALU_SUB), 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
